// File: rtl/fir_out_decim_if.sv
// Sample stream handshake between the FIR decimator and its producer/consumer.
interface fir_out_decim_if;
  logic              in_valid;
  logic signed [9:0] din;
  logic              out_ready;
  logic              out_valid;
  logic signed [9:0] dout;

  modport slave  (input  in_valid, din, out_ready, output out_valid, dout);
  modport master (output in_valid, din, out_ready, input  out_valid, dout);
endinterface

// File: rtl/fir_out_decim.sv
// FIR output decimator with output FIFO and sticky overflow flag.
// Define FIR_DECIM_AVG_EN to emit the floor-mean of each DECIM-sample window instead of the last sample.
module fir_out_decim #(
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fir_out_decim_if.slave           bus,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int unsigned PW   = $clog2(DECIM);
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LW   = PTRW + 1;

  logic [PW-1:0]     phase;
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic signed [9:0] mem [DEPTH];
  logic              valid_q;

  logic              wrap_c;
  logic              pop_c;
  logic              full_c;
  logic              wr_c;
  logic              drop_c;
  logic signed [9:0] sample_c;
  logic [LW-1:0]     level_nxt_c;

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned AW = 10 + PW;
  logic signed [AW-1:0] acc;
`endif

  // Push/pop decisions; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    wrap_c   = bus.in_valid && (phase == PW'(DECIM - 1));
    pop_c    = valid_q && bus.out_ready;
    full_c   = (level == LW'(DEPTH));
    wr_c     = wrap_c && (!full_c || pop_c);
    drop_c   = wrap_c && full_c && !pop_c;
`ifdef FIR_DECIM_AVG_EN
    sample_c = 10'((acc + AW'(bus.din)) >>> PW);
`else
    sample_c = bus.din;
`endif
    level_nxt_c = level;
    if (wr_c && !pop_c) begin
      level_nxt_c = level + LW'(1);
    end else if (!wr_c && pop_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid_q <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.in_valid) begin
        phase <= wrap_c ? '0 : phase + PW'(1);
      end
      if (wr_c) begin
        mem[wr_ptr] <= sample_c;
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      level   <= level_nxt_c;
      valid_q <= (level_nxt_c != '0);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_c) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef FIR_DECIM_AVG_EN
  // Window accumulator; cleared on the wrap that consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (bus.in_valid) begin
      acc <= wrap_c ? '0 : acc + AW'(bus.din);
    end
  end
`endif

  assign bus.out_valid = valid_q;
  assign bus.dout      = mem[rd_ptr];

endmodule

// File: tb/tb_fir_out_decim.sv
// Randomized and directed bench for fir_out_decim against a queue-based window/FIFO model.
module tb_fir_out_decim;
  localparam int unsigned DECIM = 4;
  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 ovf_clr = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic                 ovf;

  fir_out_decim_if bus ();

  fir_out_decim #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ovf_clr (ovf_clr),
    .level   (level),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int mq[$];
  int win[$];
  int seen[$];
  bit ovf_m = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int reduce_win();
    int s = 0;
    int m;
`ifdef FIR_DECIM_AVG_EN
    foreach (win[i]) s += win[i];
    m = s / int'(DECIM);
    if ((s % int'(DECIM) != 0) && (s < 0)) m -= 1;
    return m;
`else
    m = win[DECIM-1];
    return m + s;
`endif
  endfunction

  task automatic step(input bit v, input int d, input bit rdy, input bit clr);
    bit pop;
    bit prod;
    int val;
    bus.in_valid  = v;
    bus.din       = 10'(d);
    bus.out_ready = rdy;
    ovf_clr       = clr;
    pop  = (mq.size() != 0) && rdy;
    prod = 1'b0;
    val  = 0;
    if (v) begin
      win.push_back(d);
      if (win.size() == DECIM) begin
        val = reduce_win();
        win.delete();
        prod = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (prod && mq.size() >= DEPTH) ovf_m = 1'b1;
    else begin
      if (prod) mq.push_back(val);
      if (clr) ovf_m = 1'b0;
    end
    chk("out_valid", int'(bus.out_valid), int'(mq.size() != 0));
    chk("level", int'(level), mq.size());
    chk("ovf", int'(ovf), int'(ovf_m));
    if (mq.size() != 0) chk("dout", int'(bus.dout), mq[0]);
    if (bus.out_valid) seen.push_back(int'(bus.dout));
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    ovf_clr       = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_ovf", int'(ovf), 0);
    mq.delete();
    win.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[3];
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("init_valid", int'(bus.out_valid), 0);
    chk("init_level", int'(level), 0);
    chk("init_dout", int'(bus.dout), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 1..12 with consumer always ready.
    seen.delete();
    for (int i = 1; i <= 12; i++) step(1'b1, i, 1'b1, 1'b0);
`ifdef FIR_DECIM_AVG_EN
    exp_seq = '{2, 6, 10};
`else
    exp_seq = '{4, 8, 12};
`endif
    chk("ramp_count", seen.size(), 3);
    for (int i = 0; i < 3; i++) chk("ramp_val", (seen.size() > i) ? seen[i] : -9999, exp_seq[i]);

    // Fill to overflow with a stalled consumer.
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, 5, 1'b0, 1'b0);
    chk("fill_level", int'(level), 4);
    chk("fill_ovf", int'(ovf), 1);
    chk("fill_dout", int'(bus.dout), 5);

    // Clear coinciding with a drop keeps ovf; a lone clear drops it.
    for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b1);
    chk("clr_vs_drop", int'(ovf), 1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("clr_alone", int'(ovf), 0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 3; i++) step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    chk("full_pp_level", int'(level), 4);
    chk("full_pp_ovf", int'(ovf), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Extreme and negative windows.
    do_reset();
    step(1'b1, -3, 1'b1, 1'b0); step(1'b1, -3, 1'b1, 1'b0);
    step(1'b1, -3, 1'b1, 1'b0); step(1'b1, -2, 1'b1, 1'b0);
`ifdef FIR_DECIM_AVG_EN
    chk("neg_floor", int'(bus.dout), -3);
`else
    chk("neg_floor", int'(bus.dout), -2);
`endif
    for (int i = 0; i < 4; i++) step(1'b1, -512, 1'b1, 1'b0);
    chk("min_val", int'(bus.dout), -512);
    for (int i = 0; i < 4; i++) step(1'b1, 511, 1'b1, 1'b0);
    chk("max_val", int'(bus.dout), 511);

    // Reset mid-window with entries queued.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, i + 20, 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 2);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 100 + i, 1'b0, 1'b0);
    chk("post_rst_empty", int'(bus.out_valid), 0);
    step(1'b1, 103, 1'b0, 1'b0);
    chk("post_rst_first", int'(bus.out_valid), 1);

    // Random traffic: balanced, then consumer-starved to exercise drops.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)) - 512,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)) - 512,
           $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_out_decim.md
FIR_OUT_DECIM -- requirements
Module: fir_out_decim

Interface
REQ-001 Parameter DECIM, default 4, decimation factor; power of two, 2..16.
REQ-002 Parameter DEPTH, default 4, output FIFO depth in entries; power of two, 2..16.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  din carries a new filter output sample this cycle.
REQ-006 din  input  10  signed two's-complement sample, the 10-bit FIR output word.
REQ-007 out_ready  input  1  consumer accepts dout this cycle.
REQ-008 ovf_clr  input  1  synchronous clear of the ovf flag.
REQ-009 out_valid  output  1  FIFO non-empty; dout is valid.
REQ-010 dout  output  10  signed head-of-FIFO sample.
REQ-011 level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-012 ovf  output  1  sticky flag: a decimated sample was dropped.

Function
REQ-013 Phase counter, 0..DECIM-1, advances only on cycles with in_valid=1; cycles with in_valid=0 leave all state except the FIFO read side unchanged.
REQ-014 When in_valid=1 and phase=DECIM-1, the block produces one decimated sample and the phase wraps to 0.
REQ-015 The decimated sample is din of the wrapping cycle (keep every DECIM-th sample, the first one at input index DECIM-1 after reset).
REQ-016 Push: a decimated sample is written to the FIFO tail at the same clock edge that wraps the phase.
REQ-017 Pop: occurs at an edge where out_valid=1 and out_ready=1; the head advances.
REQ-018 dout is driven combinationally from the head entry; out_valid=(level!=0).
REQ-019 Latency: a sample pushed into an empty FIFO shows out_valid=1 and dout=sample in the cycle right after the push edge.
REQ-020 dout and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-021 Full (level=DEPTH) with a pop in the same cycle: push and pop both occur, level is unchanged, and no drop occurs.
REQ-022 Full with no pop: the new sample is discarded, FIFO contents are unchanged, and ovf is set at that edge.
REQ-023 Empty with out_ready=1: no pop occurs and level stays 0.
REQ-024 Read and write pointers wrap modulo DEPTH.
REQ-025 level increments on push-only, decrements on pop-only, and is unchanged on both or neither.
REQ-026 ovf stays 1 until an edge with ovf_clr=1; if a drop and ovf_clr=1 occur in the same cycle, the drop wins and ovf stays 1.
REQ-027 When the FIFO is empty, dout shows the storage entry at the read pointer, which is 0 after reset.

Reset
REQ-028 rst=0 forces, asynchronously: phase=0, FIFO pointers=0, level=0, out_valid=0, ovf=0, all storage entries=0 (hence dout=0), and the averaging accumulator=0.
REQ-029 Reset mid-operation discards all buffered and partially accumulated samples.
REQ-030 After rst rises, the first decimated sample is the DECIM-th in_valid sample.

Configuration
REQ-031 The macro FIR_DECIM_AVG_EN selects the decimation mode.
REQ-032 With FIR_DECIM_AVG_EN defined, the decimated sample is the floor-mean of the DECIM in_valid samples of the phase period.
REQ-033 In averaging mode, a signed accumulator of width 10+log2(DECIM) adds din on each in_valid cycle.
REQ-034 At the wrap, the FIFO receives (accumulator + din) arithmetically shifted right by log2(DECIM), and the accumulator is cleared to 0.
REQ-035 Without FIR_DECIM_AVG_EN, no accumulator exists and REQ-015 applies.
REQ-036 Push timing, latency and ports are identical in both modes.

Verification
REQ-037 Scenario: DECIM=4, din=1,2,...,12 with in_valid=1 every cycle and out_ready=1 -> dout sequence 4,8,12, each valid for one cycle after its push edge; with AVG_EN: 2,6,10 (floor of 2.5, 6.5, 10.5).
REQ-038 Scenario: out_ready=0, 24 valid samples of value 5 (DECIM=4, DEPTH=4) -> level reaches 4, ovf=1 after the 5th decimated sample, and dout stays 5.
REQ-039 Scenario: FIFO full, out_ready=1 held during a push cycle -> level stays 4, ovf stays 0, and the output order is preserved.
REQ-040 Scenario: AVG_EN, DECIM=4, din=-3,-3,-3,-2 -> dout=-3 (floor of -11/4); din=-512 x4 -> -512; din=511 x4 -> 511 (no overflow).
REQ-041 Scenario: rst pulsed low after 2 of 4 samples with 2 entries queued -> out_valid=0, level=0, dout=0 immediately; the next output appears after 4 new samples.
REQ-042 Scenario: ovf=1, ovf_clr=1 in the same cycle as a drop -> ovf=1; ovf_clr=1 with no drop -> ovf=0 at the next edge.
